// File: rtl/mont_mul_ctrl.sv
`timescale 1ns/1ps
// Sequencer for one radix-2 Montgomery multiply (A*B*2^-N mod M) driving the mpadder
// carry-save accumulator: bit-serial multiply, chunked carry resolve, then reduction passes.
module mont_mul_ctrl #(
    parameter int N       = 512,
    parameter int CHUNKS  = 5,
    parameter int MAX_SUB = 4
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    input  logic [N-1:0]   in_m,
    input  logic           add_czero,
    input  logic           add_sub_finished,
    input  logic [N+1:0]   add_result,
    output logic [N+1:0]   add_operand,
    output logic           add_enable,
    output logic           add_shift,
    output logic           add_subtract,
    output logic [3:0]     add_chunk,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [N-1:0]   result
);
    localparam int IDX_W  = $clog2(N);
    localparam int PASS_W = $clog2(MAX_SUB + 1);

    localparam logic [IDX_W-1:0]  LAST_BIT     = IDX_W'(N - 1);
    localparam logic [3:0]        LAST_CHUNK   = 4'(CHUNKS - 1);
    localparam logic [3:0]        CHUNK_FROZEN = 4'b1000;
    localparam logic [PASS_W-1:0] LAST_PASS    = PASS_W'(MAX_SUB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MULT,
        S_RESOLVE,
        S_SUB,
        S_DONE
    } state_t;

    state_t             state;
    logic [N-1:0]       a_reg;
    logic [N-1:0]       b_reg;
    logic [N-1:0]       m_reg;
    logic [N-1:0]       negm_reg;
    logic [IDX_W-1:0]   bit_idx;
    logic               phase;
    logic [PASS_W-1:0]  pass_cnt;

    // The two top bits of the accumulator never belong to a reduced result.
    logic unused_result_msbs;
    assign unused_result_msbs = ^add_result[N+1:N];

    // Phase 1 must see the carry-save LSB produced by phase 0 in the same cycle,
    // so the operand mux is combinational while every control strobe is registered.
    always_comb begin
        // NOTE: default first so every path assigns add_operand and no latch is inferred.
        add_operand = '0;
        case (state)
            S_MULT: begin
                if (!phase) begin
                    add_operand = a_reg[bit_idx] ? {2'b00, b_reg} : '0;
                end else begin
                    add_operand = add_czero ? {2'b00, m_reg} : '0;
                end
            end
            S_SUB:   add_operand = {2'b00, negm_reg};
            default: add_operand = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: sequential state uses non-blocking assignments only; this reset clears
            // the latched operands too, so an aborted run leaves nothing behind.
            state        <= S_IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            m_reg        <= '0;
            negm_reg     <= '0;
            bit_idx      <= '0;
            phase        <= 1'b0;
            pass_cnt     <= '0;
            add_enable   <= 1'b0;
            add_shift    <= 1'b0;
            add_subtract <= 1'b0;
            add_chunk    <= CHUNK_FROZEN;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            result       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg    <= in_a;
                        b_reg    <= in_b;
                        m_reg    <= in_m;
                        negm_reg <= ~in_m + N'(1);
                        bit_idx  <= '0;
                        phase    <= 1'b0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    add_enable <= 1'b1;
                    state      <= S_MULT;
                end

                S_MULT: begin
                    if (!phase) begin
                        add_enable <= 1'b0;
                        add_shift  <= 1'b1;
                        phase      <= 1'b1;
                    end else begin
                        add_shift <= 1'b0;
                        phase     <= 1'b0;
                        if (bit_idx == LAST_BIT) begin
                            add_chunk <= '0;
                            state     <= S_RESOLVE;
                        end else begin
                            bit_idx    <= bit_idx + IDX_W'(1);
                            add_enable <= 1'b1;
                        end
                    end
                end

                S_RESOLVE: begin
                    if (add_chunk == LAST_CHUNK) begin
                        add_chunk    <= '0;
                        add_subtract <= 1'b1;
                        pass_cnt     <= '0;
                        state        <= S_SUB;
                    end else begin
                        add_chunk <= add_chunk + 4'd1;
                    end
                end

                S_SUB: begin
                    if (add_chunk == LAST_CHUNK) begin
                        // The finished flag settles the accumulator, so the result is captured
                        // here and presented together with the done pulse.
                        if (add_sub_finished || pass_cnt == LAST_PASS) begin
                            error        <= !add_sub_finished;
                            result       <= add_result[N-1:0];
                            done         <= 1'b1;
                            add_subtract <= 1'b0;
                            add_chunk    <= CHUNK_FROZEN;
                            state        <= S_DONE;
                        end else begin
                            pass_cnt  <= pass_cnt + PASS_W'(1);
                            add_chunk <= '0;
                        end
                    end else begin
                        add_chunk <= add_chunk + 4'd1;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    a_en_sh_exclusive: assert property (@(posedge clk) disable iff (!resetn)
        !(add_enable && add_shift));
    a_sub_only_in_sub: assert property (@(posedge clk) disable iff (!resetn)
        add_subtract |-> (state == S_SUB));

endmodule
